// File: rtl/mb_poll_fsm_pkg.sv
// mb_defs: shared definitions for the Modbus slave poll engine.
// Holds the queue event codes, the poll FSM state encoding, the exception
// flag OR-ed into response function codes and the broadcast slave address.
package mb_defs;

    typedef enum logic [1:0] {
        EV_READY          = 2'd0,
        EV_FRAME_RECEIVED = 2'd1,
        EV_EXECUTE        = 2'd2,
        EV_FRAME_SENT     = 2'd3
    } ev_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPATCH = 3'd1,
        ST_RX_WAIT  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_TX_REQ   = 3'd4
    } state_t;

    localparam logic [7:0] EXC_BIT    = 8'h80;
    localparam logic [7:0] BCAST_ADDR = 8'h00;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mb_poll_fsm_timeout_cnt.sv
// mb_timeout_cnt: saturating cycle counter shared by the RX and EXEC waits.
// Ports:
//   clk, rst_n  clock, synchronous active-high reset
//   clr         force count to zero (held while not in a timed state)
//   en          count one cycle
//   limit       count value at which the wait is considered expired
//   expired     count has reached limit
module mb_timeout_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt >= limit);

endmodule

// File: rtl/mb_poll_fsm.sv
// mb_poll_fsm: Modbus slave poll engine. Pops events from the port event
// queue, fetches received frames from the RTU layer, filters on slave
// address, re-posts EV_EXECUTE, starts the function handler and requests
// the response transmission.
// Ports:
//   clk, rst_n                   clock, synchronous active-high reset
//   inEnable, inSlaveAddr        stack enable (low aborts), own address
//   inEventInQueue/inQueuedEvent queue head; outEventGet pops it
//   outEventPost/outEvent        post strobe and posted event code
//   outRxReq / inRx*             frame field fetch handshake
//   outExecStart/outExecFunc     handler start and function code
//   inExecDone/inExecExc/Code    handler completion and exception
//   outTxReq/outTxFunc/ExcCode   response request, held until inTxAck
//   outBusy                      not idle
//   outRxFrameCnt, outErrCnt     wrapping statistics counters
module mb_poll_fsm
    import mb_defs::*;
#(
    parameter int RX_TIMEOUT   = 1024,
    parameter int EXEC_TIMEOUT = 65535,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inEnable,
    input  logic [7:0]       inSlaveAddr,
    input  logic             inEventInQueue,
    input  logic [1:0]       inQueuedEvent,
    output logic             outEventGet,
    output logic             outEventPost,
    output logic [1:0]       outEvent,
    output logic             outRxReq,
    input  logic             inRxAck,
    input  logic             inRxOk,
    input  logic [7:0]       inRxAddr,
    input  logic [7:0]       inRxFunc,
    output logic             outExecStart,
    output logic [7:0]       outExecFunc,
    input  logic             inExecDone,
    input  logic             inExecExc,
    input  logic [7:0]       inExecExcCode,
    output logic             outTxReq,
    output logic [7:0]       outTxFunc,
    output logic [7:0]       outTxExcCode,
    input  logic             inTxAck,
    output logic             outBusy,
    output logic [CNT_W-1:0] outRxFrameCnt,
    output logic [CNT_W-1:0] outErrCnt
);

    localparam int TO_W = $clog2(max2(RX_TIMEOUT, EXEC_TIMEOUT) + 1);
    // Expired is raised during the last allowed cycle, so the wait gives up
    // on the edge that ends exactly RX_TIMEOUT / EXEC_TIMEOUT cycles.
    localparam logic [TO_W-1:0] RX_LIM   = TO_W'(RX_TIMEOUT - 1);
    localparam logic [TO_W-1:0] EXEC_LIM = TO_W'(EXEC_TIMEOUT - 1);

    state_t          state;
    ev_t             ev;
    logic [7:0]      rx_addr;
    logic            to_clr;
    logic            to_expired;
    logic [TO_W-1:0] to_limit;
    logic            addr_hit;

    // Counter sits at zero outside the timed states, so it restarts on entry.
    assign to_clr   = !((state == ST_RX_WAIT) || (state == ST_EXEC));
    assign to_limit = (state == ST_RX_WAIT) ? RX_LIM : EXEC_LIM;
    assign addr_hit = (inRxAddr == inSlaveAddr) || (inRxAddr == BCAST_ADDR);
    assign outBusy  = (state != ST_IDLE);

    mb_timeout_cnt #(.W(TO_W)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (inEnable),
        .limit   (to_limit),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= ST_IDLE;
            ev            <= EV_READY;
            rx_addr       <= '0;
            outEventGet   <= 1'b0;
            outEventPost  <= 1'b0;
            outEvent      <= EV_READY;
            outRxReq      <= 1'b0;
            outExecStart  <= 1'b0;
            outExecFunc   <= '0;
            outTxReq      <= 1'b0;
            outTxFunc     <= '0;
            outTxExcCode  <= '0;
            outRxFrameCnt <= '0;
            outErrCnt     <= '0;
        end else begin
            outEventGet  <= 1'b0;
            outEventPost <= 1'b0;
            outExecStart <= 1'b0;
            if (!inEnable) begin
                state    <= ST_IDLE;
                outRxReq <= 1'b0;
                outTxReq <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (inEventInQueue) begin
                            outEventGet <= 1'b1;
                            ev          <= ev_t'(inQueuedEvent);
                            state       <= ST_DISPATCH;
                        end
                    end
                    ST_DISPATCH: begin
                        case (ev)
                            EV_FRAME_RECEIVED: begin
                                outRxReq <= 1'b1;
                                state    <= ST_RX_WAIT;
                            end
                            EV_EXECUTE: begin
                                outExecStart <= 1'b1;
                                state        <= ST_EXEC;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                    ST_RX_WAIT: begin
                        if (inRxAck) begin
                            outRxReq <= 1'b0;
                            state    <= ST_IDLE;
                            if (inRxOk && addr_hit) begin
                                rx_addr       <= inRxAddr;
                                outExecFunc   <= inRxFunc;
                                outEventPost  <= 1'b1;
                                outEvent      <= EV_EXECUTE;
                                outRxFrameCnt <= outRxFrameCnt + 1'b1;
                            end else if (!inRxOk) begin
                                // Foreign-address frames drop silently.
                                outErrCnt <= outErrCnt + 1'b1;
                            end
                        end else if (to_expired) begin
                            outRxReq  <= 1'b0;
                            outErrCnt <= outErrCnt + 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_EXEC: begin
                        if (inExecDone) begin
                            if (rx_addr == BCAST_ADDR) begin
                                state <= ST_IDLE;   // broadcasts get no reply
                            end else begin
                                outTxFunc    <= inExecExc ? (outExecFunc | EXC_BIT) : outExecFunc;
                                outTxExcCode <= inExecExc ? inExecExcCode : 8'h00;
                                outTxReq     <= 1'b1;
                                state        <= ST_TX_REQ;
                            end
                        end else if (to_expired) begin
                            outErrCnt <= outErrCnt + 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_TX_REQ: begin
                        if (inTxAck) begin
                            outTxReq <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
